// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Items shared by the alu, the operand loader and their testbenches:
//   - default operand and opcode widths
//   - the eight opcode encodings
//   - is_legal_opcode(): 1 when an opcode is one of the eight listed below
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEF_NB_DATA   = 8;
    localparam int DEF_NB_OPCODE = 6;

    localparam logic [DEF_NB_OPCODE-1:0] OP_ADD = 6'b100000;
    localparam logic [DEF_NB_OPCODE-1:0] OP_SUB = 6'b100010;
    localparam logic [DEF_NB_OPCODE-1:0] OP_AND = 6'b100100;
    localparam logic [DEF_NB_OPCODE-1:0] OP_OR  = 6'b100101;
    localparam logic [DEF_NB_OPCODE-1:0] OP_XOR = 6'b100110;
    localparam logic [DEF_NB_OPCODE-1:0] OP_SRA = 6'b000011;
    localparam logic [DEF_NB_OPCODE-1:0] OP_SRL = 6'b000010;
    localparam logic [DEF_NB_OPCODE-1:0] OP_NOR = 6'b100111;

    function automatic logic is_legal_opcode(input logic [DEF_NB_OPCODE-1:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
// Collects operand 1, operand 2 and opcode bytes from a valid/ready stream,
// drives the combinational alu from registers, captures the alu result one
// cycle later and hands it downstream over a valid/ready handshake.
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_data, i_valid     incoming byte stream
//   o_ready             high in the three WAIT states (byte can be accepted)
//   i_abort             synchronous abort, returns to S_WAIT_A
//   o_op_1, o_op_2,     registered alu inputs, held until overwritten
//   o_opcode
//   i_alu_result        alu output
//   o_result,           captured result, held until i_result_ready
//   o_result_valid
//   i_result_ready      downstream accepts the result
//   o_error             one-cycle pulse when an illegal opcode is accepted
//   o_count             completed transactions, wraps
// -----------------------------------------------------------------------------
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int NB_DATA   = DEF_NB_DATA,
    parameter int NB_OPCODE = DEF_NB_OPCODE,
    parameter int NB_COUNT  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_abort,
    output logic [NB_DATA-1:0]   o_op_1,
    output logic [NB_DATA-1:0]   o_op_2,
    output logic [NB_OPCODE-1:0] o_opcode,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_result_valid,
    input  logic                 i_result_ready,
    output logic                 o_error,
    output logic [NB_COUNT-1:0]  o_count
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NB_DATA-1:0]   r_op_1;
    logic [NB_DATA-1:0]   r_op_2;
    logic [NB_OPCODE-1:0] r_opcode;
    logic [NB_DATA-1:0]   r_result;
    logic                 r_error;
    logic [NB_COUNT-1:0]  r_count;

    logic w_accept;
    logic w_opcode_legal;
    logic w_load_op_1;
    logic w_load_op_2;
    logic w_load_opcode;
    logic w_set_error;
    logic w_capture;
    logic w_done;

    // Abort blocks acceptance, so a byte offered alongside it is simply dropped
    // by the source's own retry rather than half-consumed here.
    assign o_ready        = (r_state == S_WAIT_A) || (r_state == S_WAIT_B) ||
                            (r_state == S_WAIT_OP);
    assign w_accept       = i_valid && o_ready && !i_abort;
    assign w_opcode_legal = is_legal_opcode(i_data[NB_OPCODE-1:0]);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_next_state  = r_state;
        w_load_op_1   = 1'b0;
        w_load_op_2   = 1'b0;
        w_load_opcode = 1'b0;
        w_set_error   = 1'b0;
        w_capture     = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_WAIT_A: if (w_accept) begin
                w_load_op_1  = 1'b1;
                w_next_state = S_WAIT_B;
            end
            S_WAIT_B: if (w_accept) begin
                w_load_op_2  = 1'b1;
                w_next_state = S_WAIT_OP;
            end
            S_WAIT_OP: if (w_accept) begin
                if (w_opcode_legal) begin
                    w_load_opcode = 1'b1;
                    w_next_state  = S_EXEC;
                end else begin
                    w_set_error  = 1'b1;
                    w_next_state = S_WAIT_A;
                end
            end
            S_EXEC: begin
                // The alu has had a full cycle to settle on the new operands.
                w_capture    = !i_abort;
                w_next_state = S_RESP;
            end
            S_RESP: if (i_result_ready && !i_abort) begin
                w_done       = 1'b1;
                w_next_state = S_WAIT_A;
            end
            default: w_next_state = S_WAIT_A;
        endcase

        // Abort overrides every transition above.
        if (i_abort) begin
            w_next_state = S_WAIT_A;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_WAIT_A;
            r_op_1   <= '0;
            r_op_2   <= '0;
            r_opcode <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            r_error <= w_set_error;
            if (w_load_op_1)   r_op_1   <= i_data;
            if (w_load_op_2)   r_op_2   <= i_data;
            if (w_load_opcode) r_opcode <= i_data[NB_OPCODE-1:0];
            if (w_capture)     r_result <= i_alu_result;
            if (w_done)        r_count  <= r_count + NB_COUNT'(1);
        end
    end

    assign o_op_1         = r_op_1;
    assign o_op_2         = r_op_2;
    assign o_opcode       = r_opcode;
    assign o_result       = r_result;
    assign o_result_valid = (r_state == S_RESP);
    assign o_error        = r_error;
    assign o_count        = r_count;

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
// Directed testbench for alu_operand_loader. A small behavioural alu closes
// the loop between the operand registers and i_alu_result; all expected
// values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;
    import alu_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       i_abort = 1'b0;
    logic [7:0] o_op_1;
    logic [7:0] o_op_2;
    logic [5:0] o_opcode;
    logic [7:0] w_alu_result;
    logic [7:0] o_result;
    logic       o_result_valid;
    logic       i_result_ready = 1'b1;
    logic       o_error;
    logic [7:0] o_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    alu_operand_loader dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_abort        (i_abort),
        .o_op_1         (o_op_1),
        .o_op_2         (o_op_2),
        .o_opcode       (o_opcode),
        .i_alu_result   (w_alu_result),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_error        (o_error),
        .o_count        (o_count)
    );

    // Behavioural alu standing in for the real one.
    always_comb begin
        w_alu_result = '0;
        case (o_opcode)
            OP_ADD: w_alu_result = o_op_1 + o_op_2;
            OP_SUB: w_alu_result = o_op_1 - o_op_2;
            OP_AND: w_alu_result = o_op_1 & o_op_2;
            OP_OR:  w_alu_result = o_op_1 | o_op_2;
            OP_XOR: w_alu_result = o_op_1 ^ o_op_2;
            OP_SRA: w_alu_result = $signed(o_op_1) >>> o_op_2;
            OP_SRL: w_alu_result = o_op_1 >> o_op_2;
            OP_NOR: w_alu_result = ~(o_op_1 | o_op_2);
            default: w_alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        i_data  = d;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    // Full transaction with i_result_ready held high.
    task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] op, input logic [7:0] exp_res,
                       input logic [7:0] exp_cnt);
        send_byte(a);
        send_byte(b);
        send_byte({2'b00, op});
        // In S_EXEC: operands visible, result not yet valid.
        check({tag, "_exec_valid"}, 32'(o_result_valid), 32'd0);
        check({tag, "_op1"},        32'(o_op_1),   32'(a));
        check({tag, "_op2"},        32'(o_op_2),   32'(b));
        check({tag, "_opcode"},     32'(o_opcode), 32'(op));
        tick();
        check({tag, "_valid"},  32'(o_result_valid), 32'd1);
        check({tag, "_result"}, 32'(o_result),       32'(exp_res));
        tick();
        check({tag, "_done_valid"}, 32'(o_result_valid), 32'd0);
        check({tag, "_count"},      32'(o_count),        32'(exp_cnt));
        check({tag, "_ready"},      32'(o_ready),        32'd1);
    endtask

    initial begin
        // Reset.
        #2 i_reset = 1'b1;
        #1;
        check("rst_ready",  32'(o_ready),        32'd1);
        check("rst_valid",  32'(o_result_valid), 32'd0);
        check("rst_count",  32'(o_count),        32'd0);
        check("rst_op1",    32'(o_op_1),         32'd0);
        check("rst_opcode", 32'(o_opcode),       32'd0);
        check("rst_error",  32'(o_error),        32'd0);
        tick();
        i_reset = 1'b0;

        // ADD, SUB, SRA.
        txn("add", 8'h05, 8'h03, OP_ADD, 8'h08, 8'd1);
        txn("sub", 8'h03, 8'h05, OP_SUB, 8'hFE, 8'd2);
        txn("sra", 8'h80, 8'h02, OP_SRA, 8'hE0, 8'd3);

        // Illegal opcode 0x3F.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h3F);
        check("ill_error",  32'(o_error),        32'd1);
        check("ill_opcode", 32'(o_opcode),       32'(OP_SRA));
        check("ill_valid",  32'(o_result_valid), 32'd0);
        check("ill_ready",  32'(o_ready),        32'd1);
        tick();
        check("ill_error_pulse", 32'(o_error),   32'd0);
        check("ill_count",       32'(o_count),   32'd3);

        // Backpressure: AND 0x07 & 0x09 = 0x01, stalled five cycles.
        i_result_ready = 1'b0;
        send_byte(8'h07);
        send_byte(8'h09);
        send_byte({2'b00, OP_AND});
        tick();
        check("bp_valid",  32'(o_result_valid), 32'd1);
        check("bp_result", 32'(o_result),       32'h01);
        for (int i = 0; i < 5; i++) begin
            i_data  = 8'hAA;
            i_valid = 1'b1;
            tick();
            check("bp_hold_valid",  32'(o_result_valid), 32'd1);
            check("bp_hold_result", 32'(o_result),       32'h01);
            check("bp_hold_ready",  32'(o_ready),        32'd0);
        end
        i_valid        = 1'b0;
        i_result_ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(o_result_valid), 32'd0);
        check("bp_count",      32'(o_count),        32'd4);
        check("bp_op1_kept",   32'(o_op_1),         32'h07);

        // Abort in S_WAIT_OP together with a valid opcode byte.
        send_byte(8'h11);
        send_byte(8'h22);
        i_abort = 1'b1;
        i_data  = {2'b00, OP_ADD};
        i_valid = 1'b1;
        tick();
        i_abort = 1'b0;
        i_valid = 1'b0;
        check("abt_error",  32'(o_error),        32'd0);
        check("abt_ready",  32'(o_ready),        32'd1);
        check("abt_opcode", 32'(o_opcode),       32'(OP_AND));
        check("abt_op1",    32'(o_op_1),         32'h11);
        check("abt_op2",    32'(o_op_2),         32'h22);
        check("abt_count",  32'(o_count),        32'd4);
        // Back in S_WAIT_A: the next byte must land in operand 1.
        txn("or", 8'h40, 8'h01, OP_OR, 8'h41, 8'd5);

        // Abort in S_RESP with i_result_ready high: no count.
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte({2'b00, OP_ADD});
        tick();
        check("abr_valid", 32'(o_result_valid), 32'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abr_valid_clr", 32'(o_result_valid), 32'd0);
        check("abr_count",     32'(o_count),        32'd5);
        check("abr_ready",     32'(o_ready),        32'd1);

        // Reset asserted mid-S_RESP, checked before the next clock edge.
        i_result_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte({2'b00, OP_ADD});
        tick();
        check("mrst_pre_valid", 32'(o_result_valid), 32'd1);
        #2 i_reset = 1'b1;
        #1;
        check("mrst_valid",  32'(o_result_valid), 32'd0);
        check("mrst_result", 32'(o_result),       32'd0);
        check("mrst_op1",    32'(o_op_1),         32'd0);
        check("mrst_count",  32'(o_count),        32'd0);
        check("mrst_ready",  32'(o_ready),        32'd1);
        tick();
        i_reset        = 1'b0;
        i_result_ready = 1'b1;

        // 256 completed transactions from reset wrap the counter.
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(8'h01);
            send_byte({2'b00, OP_ADD});
            tick();
            tick();
            if (i == 254) check("wrap_255", 32'(o_count), 32'd255);
        end
        check("wrap_0",      32'(o_count),  32'd0);
        check("wrap_result", 32'(o_result), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
